lvds_tx: RTL and testbench
==========================

Name: lvds_tx

Overview:
TX-path serializer for the modem LVDS interface; the transmit counterpart of the existing LVDS receive path.
- Pulls 32-bit I/Q words from the TX complex_fifo read side and serializes each word MSB-first as 16 DDR bit-pairs.
- Feeds the DDR output SB_IO that drives o_iq_tx_p/n.
- Clocked by the buffered modem LVDS clock; the same clock drives o_iq_tx_clk.

Parameters:
- WORD_BITS, 32, bits per I/Q word; must be even.
- FORCE_SYNC, 1, when 1, sync fields are overwritten on load: [31:30]=2'b10, [15:14]=2'b01.

Ports:
- i_ddr_clk  in  1  buffered modem LVDS clock; the single clock of the block.
- i_rst_b  in  1  asynchronous, active-low reset.
- i_tx_enable  in  1  level; stream enable.
- i_fifo_empty  in  1  TX FIFO empty flag.
- i_fifo_data  in  32  FIFO read data; valid the cycle after o_fifo_pull.
- o_fifo_pull  out  1  FIFO read strobe, one cycle per word.
- o_ddr_data  out  2  [1] = rising-edge bit, [0] = falling-edge bit; goes to SB_IO D_OUT_0/D_OUT_1.
- o_busy  out  1  high while in ACTIVE.
- i_clear_underrun  in  1  one-cycle pulse; clears o_underrun.
- o_underrun  out  1  sticky underrun flag.

Behaviour:
- Reset:
  - o_ddr_data=00, o_fifo_pull=0, o_busy=0, o_underrun=0.
  - r_next_vld=0, r_pull_pend=0, phase=0, state=IDLE, shift register=0.
  - A reset in the middle of a word aborts it immediately; output goes to 00 asynchronously.
- Prefetch register (r_next, r_next_vld):
  - o_fifo_pull = i_tx_enable & ~i_fifo_empty & ~r_next_vld & ~r_pull_pend (combinational).
  - On a pull edge, r_pull_pend is set. On the next edge, r_next <= i_fifo_data, r_next_vld=1, r_pull_pend=0.
  - Never more than one word is in flight; no pulls occur while i_tx_enable=0.
- Output register: o_ddr_data = r_shift[31:30]. Each ACTIVE cycle, r_shift <= r_shift<<2.
- Load:
  - r_shift <= r_next, with sync fields forced when FORCE_SYNC=1.
  - r_next_vld cleared on the load edge; a prefetch for the next word starts in the following cycle. 16 cycles of margin is sufficient.
- States:
  - IDLE: o_ddr_data=00. On an edge where i_tx_enable & r_next_vld: load, phase=0, go ACTIVE.
    - Latency: the first pair word[31:30] is on o_ddr_data in the cycle following that edge.
  - ACTIVE: phase counts 0..15 and wraps. At the phase=15 edge:
    - if i_tx_enable=0: go IDLE, output 00 next cycle. The word in r_next is retained, so no sample is lost.
    - else if r_next_vld: load next word, phase=0. This gives back-to-back words with no gap.
    - else (underrun): load 32'h0, set o_underrun, stay ACTIVE, phase=0. One idle slot of 16 cycles of 00 is sent, which keeps slot alignment.
- Enable deassert mid-word: the current word always completes; partial words are never sent.
- o_underrun:
  - Set on an underrun load; cleared by i_clear_underrun.
  - If set and clear occur in the same cycle, set wins.
- o_busy = (state==ACTIVE).
- The bit-pair for phase k is word[31-2k : 30-2k].

Decomposition:
- Shared package lvds_pkg, also to be adopted by lvds_rx:
  - LVDS_WORD_BITS=32, PAIRS_PER_WORD=16.
  - I_SYNC=2'b10, Q_SYNC=2'b01, IDLE_WORD=32'h0.
  - State enum {IDLE, ACTIVE}.
- No sub-module; prefetch, FSM and shifter live in one module of about 150–250 lines.
- The SB_IO DDR output instance stays in top.

Test Plan:
- Single word: FIFO holds 32'h8123_4567, enable=1.
  - Expect one pull, then 16 pairs 10,00,00,01,00,10,00,11,01,00,01,01,01,10,01,11.
  - Then 00 with busy=0 after enable drop.
  - (8123_4567 already carries valid sync, so FORCE_SYNC leaves it unchanged.)
- Back-to-back: 3 words preloaded, enable held high.
  - Expect 48 consecutive pair cycles with no 00 gap between words and exactly 3 pulls.
  - Each pull lands 1–2 cycles after the preceding load.
- Underrun: 1 word, then FIFO empty for 20 cycles, then 1 word.
  - Expect word1, then 16 cycles of 00 with o_underrun=1 and busy=1, then word2 starting at a phase-0 boundary.
  - o_underrun stays 1 until a clear pulse, then reads 0.
- FORCE_SYNC: push 32'h0000_0000 with FORCE_SYNC=1.
  - Expect first pair 10 and pair 8 (phase 8) 01; all other pairs 00.
- Enable drop mid-word: deassert at phase 5.
  - Expect remaining pairs 6..15 sent, then IDLE.
  - The prefetched word is held; re-enable sends it without a new pull first.
- Async reset at phase 7: assert i_rst_b=0 between clock edges.
  - o_ddr_data=00 and o_busy=0 immediately.
  - After release, no pull until enable=1 and FIFO is non-empty.

Source files
------------

// File: rtl/lvds_pkg.sv
// Shared constants and state type for the modem LVDS TX and RX paths.
package lvds_pkg;
  localparam int LVDS_WORD_BITS = 32;
  localparam int PAIRS_PER_WORD = LVDS_WORD_BITS / 2;
  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;
  localparam logic [LVDS_WORD_BITS-1:0] IDLE_WORD = 32'h0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } lvds_state_t;
endpackage

// File: rtl/lvds_tx.sv
// LVDS TX serializer: prefetches I/Q words from the TX FIFO, shifts them out MSB-first as DDR bit-pairs.
// Latency: first pair appears 3 cycles after a pull from idle; back-to-back words have no gap.
// Backpressure: one word in flight at most; FIFO starvation sends a 16-cycle all-zero slot and flags underrun.
module lvds_tx
  import lvds_pkg::*;
#(
  parameter int WORD_BITS  = LVDS_WORD_BITS,
  parameter bit FORCE_SYNC = 1'b1
) (
  input  logic                 i_ddr_clk,
  input  logic                 i_rst_b,
  input  logic                 i_tx_enable,
  input  logic                 i_fifo_empty,
  input  logic [WORD_BITS-1:0] i_fifo_data,
  output logic                 o_fifo_pull,
  output logic [1:0]           o_ddr_data,
  output logic                 o_busy,
  input  logic                 i_clear_underrun,
  output logic                 o_underrun
);

  localparam int PAIRS = WORD_BITS / 2;
  localparam int PW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PAIRS - 1);

  lvds_state_t          state, state_nxt;
  logic [PW-1:0]        r_phase;
  logic [WORD_BITS-1:0] r_shift;
  logic [WORD_BITS-1:0] r_next;
  logic                 r_next_vld;
  logic                 r_pull_pend;
  logic                 r_underrun;
  logic                 last_pair;
  logic                 load_next;
  logic                 load_idle;

  function automatic logic [WORD_BITS-1:0] with_sync(input logic [WORD_BITS-1:0] w);
    logic [WORD_BITS-1:0] s;
    s = w;
    if (FORCE_SYNC) begin
      s[WORD_BITS-1 -: 2]   = I_SYNC;
      s[WORD_BITS/2-1 -: 2] = Q_SYNC;
    end
    return s;
  endfunction

  assign last_pair   = (r_phase == LAST_PHASE);
  assign o_fifo_pull = i_tx_enable & ~i_fifo_empty & ~r_next_vld & ~r_pull_pend;
  assign o_ddr_data  = r_shift[WORD_BITS-1 -: 2];
  assign o_underrun  = r_underrun;

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_tx_enable && r_next_vld) state_nxt = ACTIVE;
      ACTIVE:  if (last_pair && !i_tx_enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Loads only happen on word boundaries, so a disable never truncates a word.
  always_comb begin
    load_next = 1'b0;
    load_idle = 1'b0;
    o_busy    = 1'b0;
    case (state)
      IDLE: begin
        load_next = i_tx_enable & r_next_vld;
      end
      ACTIVE: begin
        o_busy = 1'b1;
        if (last_pair && i_tx_enable) begin
          load_next = r_next_vld;
          load_idle = ~r_next_vld;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_next      <= '0;
      r_next_vld  <= 1'b0;
      r_pull_pend <= 1'b0;
    end else begin
      r_pull_pend <= o_fifo_pull;
      if (r_pull_pend) begin
        r_next     <= i_fifo_data;
        r_next_vld <= 1'b1;
      end else if (load_next) begin
        r_next_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_shift <= '0;
      r_phase <= '0;
    end else if (load_next) begin
      r_shift <= with_sync(r_next);
      r_phase <= '0;
    end else if (load_idle) begin
      r_shift <= WORD_BITS'(IDLE_WORD);
      r_phase <= '0;
    end else if (state == ACTIVE) begin
      r_shift <= r_shift << 2;
      r_phase <= r_phase + PW'(1);
    end
  end

  // A set on the same edge as a clear takes priority so no underrun is missed.
  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_underrun <= 1'b0;
    end else if (load_idle) begin
      r_underrun <= 1'b1;
    end else if (i_clear_underrun) begin
      r_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lvds_tx.sv
// Bench for lvds_tx: table-driven single words, directed corner sequences and a randomized stream.
module tb_lvds_tx;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] rd_data = 32'h0;
  logic        empty;
  logic        pull;
  logic [1:0]  ddr;
  logic        busy;
  logic        und;

  logic [31:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pulls = 0;
  int          checks = 0;
  int          errors = 0;

  vec_t        tbl [6];
  logic [1:0]  exp_pairs [16];

  always #5 clk = ~clk;

  assign empty = (wr_ptr == rd_ptr);

  lvds_tx dut (
    .i_ddr_clk       (clk),
    .i_rst_b         (rst_b),
    .i_tx_enable     (en),
    .i_fifo_empty    (empty),
    .i_fifo_data     (rd_data),
    .o_fifo_pull     (pull),
    .o_ddr_data      (ddr),
    .o_busy          (busy),
    .i_clear_underrun(clr),
    .o_underrun      (und)
  );

  // FIFO model with registered read data, valid the cycle after a pull
  always @(posedge clk) begin
    if (pull) begin
      checks++;
      if (empty || !en) begin
        errors++;
        $display("FAIL pull_legal: pull=1 with empty=%0b en=%0b, required no pull", empty, en);
      end
      rd_data <= mem[rd_ptr[7:0]];
      rd_ptr  <= rd_ptr + 1;
      pulls   <= pulls + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  function automatic logic [31:0] synced(input logic [31:0] w);
    return (w & 32'h3FFF_3FFF) | 32'h8000_4000;
  endfunction

  task automatic wait_busy(output int lat);
    lat = 0;
    while (!busy && lat < 40) begin
      step();
      lat++;
    end
  endtask

  // Collect 16 pairs starting at the current sample; drop enable after pair drop_at.
  task automatic grab_word(input int drop_at, output logic [31:0] w);
    w = 32'h0;
    for (int k = 0; k < 16; k++) begin
      w = {w[29:0], ddr};
      if (k == drop_at) en = 1'b0;
      step();
    end
  endtask

  initial begin
    int          lat;
    int          p0;
    int          s;
    int          gaps;
    int          wi;
    int          t;
    int          tend;
    int          nxt;
    int          bound;
    logic [31:0] w;
    logic [31:0] wa;
    logic [31:0] wb;
    logic [31:0] wc;
    logic [1:0]  rec_dat [$];
    bit          rec_busy [$];
    bit          rec_und [$];
    int          pull_idx [$];
    int          t_push [12];
    logic [31:0] rw [12];

    tbl[0] = '{32'h8123_4567, 32'h8123_4567};
    tbl[1] = '{32'h0000_0000, 32'h8000_4000};
    tbl[2] = '{32'hFFFF_FFFF, 32'hBFFF_7FFF};
    tbl[3] = '{32'h1234_5678, 32'h9234_5678};
    tbl[4] = '{32'hC3C3_C3C3, 32'h83C3_43C3};
    tbl[5] = '{32'h4000_8000, 32'h8000_4000};
    exp_pairs = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11,
                  2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b11};

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    chk("reset_ddr", ddr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_underrun", und, 0);
    chk("reset_pull", pull, 0);
    rst_b = 1'b1;
    step();

    // Single word, pair by pair
    p0 = pulls;
    push(32'h8123_4567);
    en = 1'b1;
    wait_busy(lat);
    chk("single_latency", lat, 3);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("single_pair%0d", k), ddr, exp_pairs[k]);
      if (k == 0) en = 1'b0;
      step();
    end
    chk("single_idle_busy", busy, 0);
    chk("single_idle_ddr", ddr, 0);
    chk("single_pulls", pulls - p0, 1);

    // Table of words incl. sync forcing
    for (int v = 0; v < 6; v++) begin
      p0 = pulls;
      push(tbl[v].din);
      en = 1'b1;
      wait_busy(lat);
      chk($sformatf("tbl%0d_latency", v), lat, 3);
      grab_word(0, w);
      chk($sformatf("tbl%0d_word", v), w, tbl[v].dout);
      chk($sformatf("tbl%0d_idle", v), busy, 0);
      chk($sformatf("tbl%0d_pulls", v), pulls - p0, 1);
    end

    // Back-to-back: three preloaded words
    wa = 32'hA5A5_1234;
    wb = 32'h0F0F_F0F0;
    wc = 32'h8001_4002;
    push(wa); push(wb); push(wc);
    p0 = pulls;
    en = 1'b1;
    wait_busy(lat);
    chk("b2b_latency", lat, 3);
    rec_dat.delete();
    gaps = 0;
    pull_idx.delete();
    for (int i = 0; i < 48; i++) begin
      rec_dat.push_back(ddr);
      if (!busy) gaps++;
      if (pull) pull_idx.push_back(i);
      if (i == 40) en = 1'b0;
      step();
    end
    chk("b2b_busy_gaps", gaps, 0);
    for (int j = 0; j < 3; j++) begin
      w = 32'h0;
      for (int k = 0; k < 16; k++) w = {w[29:0], rec_dat[j*16+k]};
      chk($sformatf("b2b_word%0d", j), w, synced(j == 0 ? wa : (j == 1 ? wb : wc)));
    end
    chk("b2b_pulls", pulls - p0, 3);
    chk("b2b_pulls_in_window", pull_idx.size(), 2);
    for (int j = 0; j < pull_idx.size(); j++)
      chk($sformatf("b2b_pull%0d_near_load", j), (pull_idx[j] - 16*j) inside {0, 1}, 1);
    chk("b2b_end_idle", busy, 0);
    chk("b2b_no_underrun", und, 0);

    // Underrun: one word, starvation, one word
    wa = 32'h1357_9BDF;
    wb = 32'h2468_ACE0;
    p0 = pulls;
    push(wa);
    en = 1'b1;
    wait_busy(lat);
    rec_dat.delete(); rec_busy.delete(); rec_und.delete();
    for (int i = 0; i < 48; i++) begin
      rec_dat.push_back(ddr);
      rec_busy.push_back(busy);
      rec_und.push_back(und);
      if (i == 19) push(wb);
      if (i == 15) clr = 1'b1;
      if (i == 16) clr = 1'b0;
      if (i == 33) en = 1'b0;
      step();
    end
    gaps = 0;
    for (int i = 16; i < 32; i++) if (!rec_busy[i]) gaps++;
    chk("urun_busy_in_slot", gaps, 0);
    chk("urun_flag_before", rec_und[0], 0);
    chk("urun_set_wins_clear", rec_und[16], 1);
    chk("urun_flag_slot_end", rec_und[31], 1);
    for (int j = 0; j < 3; j++) begin
      w = 32'h0;
      for (int k = 0; k < 16; k++) w = {w[29:0], rec_dat[j*16+k]};
      chk($sformatf("urun_slot%0d", j), w, j == 0 ? synced(wa) : (j == 1 ? 32'h0 : synced(wb)));
    end
    chk("urun_end_idle", busy, 0);
    chk("urun_sticky", und, 1);
    chk("urun_pulls", pulls - p0, 2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("urun_cleared", und, 0);

    // Enable drop at phase 5; prefetched word held
    wa = 32'h7654_3210;
    wb = 32'hDEAD_BEEF;
    p0 = pulls;
    push(wa); push(wb);
    en = 1'b1;
    wait_busy(lat);
    grab_word(5, w);
    chk("drop_word_complete", w, synced(wa));
    chk("drop_idle", busy, 0);
    repeat (3) step();
    chk("drop_idle_ddr", ddr, 0);
    chk("drop_prefetch_pulls", pulls - p0, 2);
    en = 1'b1;
    wait_busy(lat);
    chk("drop_resume_latency", lat, 1);
    grab_word(0, w);
    chk("drop_resume_word", w, synced(wb));
    chk("drop_no_new_pull", pulls - p0, 2);

    // Randomized stream with random FIFO gaps
    t = 5;
    for (int i = 0; i < 12; i++) begin
      rw[i] = $urandom;
      t_push[i] = t;
      t += $urandom_range(0, 40);
    end
    tend = t_push[11] + 100;
    p0 = pulls;
    nxt = 0;
    rec_dat.delete(); rec_busy.delete(); rec_und.delete();
    en = 1'b1;
    for (int c = 0; c < tend; c++) begin
      rec_dat.push_back(ddr);
      rec_busy.push_back(busy);
      rec_und.push_back(und);
      while (nxt < 12 && t_push[nxt] == c) begin
        push(rw[nxt]);
        nxt++;
      end
      step();
    end
    en = 1'b0;
    bound = 0;
    while (busy && bound < 20) begin
      step();
      bound++;
    end
    chk("rand_stops", busy, 0);
    s = -1;
    for (int i = 0; i < tend; i++) if (s < 0 && rec_busy[i]) s = i;
    chk("rand_started", s >= 0, 1);
    if (s >= 0) begin
      gaps = 0;
      for (int i = s; i < tend; i++) if (!rec_busy[i]) gaps++;
      chk("rand_busy_gaps", gaps, 0);
      wi = 0;
      for (int b = s; b + 16 <= tend; b += 16) begin
        w = 32'h0;
        for (int k = 0; k < 16; k++) w = {w[29:0], rec_dat[b+k]};
        if (w == 32'h0) begin
          chk($sformatf("rand_urun_flag@%0d", b), rec_und[b], 1);
        end else begin
          chk($sformatf("rand_word%0d", wi), w, wi < 12 ? synced(rw[wi]) : 32'h0);
          wi++;
        end
      end
      chk("rand_word_count", wi, 12);
    end
    chk("rand_pulls", pulls - p0, 12);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Async reset in mid-word at phase 7
    push(32'hCAFE_F00D);
    en = 1'b1;
    wait_busy(lat);
    repeat (7) step();
    #2;
    rst_b = 1'b0;
    en = 1'b0;
    #1;
    chk("arst_ddr", ddr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_underrun", und, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_b = 1'b1;
    p0 = pulls;
    wa = 32'h0BAD_CAFE;
    push(wa);
    repeat (4) step();
    chk("arst_no_pull_disabled", pulls - p0, 0);
    chk("arst_idle_after", busy, 0);
    en = 1'b1;
    wait_busy(lat);
    chk("arst_restart_latency", lat, 3);
    chk("arst_restart_pulls", pulls - p0, 1);
    grab_word(0, w);
    chk("arst_restart_word", w, synced(wa));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
